// File: rtl/jtag_debug_cmd_sync.sv
// Moves virtual-JTAG debug commands from the TCK domain into the system clock.
// The level-synchronized update-DR edge pushes {ir_in, sr} into a small FWFT FIFO.
module jtag_debug_cmd_sync #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vs_udr,
  input  logic                            vs_uir,
  input  logic [IR_W-1:0]                 ir_in,
  input  logic [DATA_W-1:0]               sr,
  input  logic                            cmd_ready,
  input  logic                            clear_overflow,
  output logic                            cmd_valid,
  output logic [IR_W-1:0]                 cmd_ir,
  output logic [DATA_W-1:0]               jdo,
  output logic [(2**IR_W)-1:0]            take_action,
  output logic                            ir_update,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int ACT_W = 2 ** IR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = IR_W + DATA_W;

  // Synchronizer chains, edge-detect flops and arming state
  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   udr_q;
  logic                   uir_q;
  logic                   udr_armed;
  logic                   uir_armed;
  logic                   udr_out;
  logic                   uir_out;
  logic                   udr_rise;
  logic                   uir_rise;

  assign udr_out = udr_sync[SYNC_STAGES-1];
  assign uir_out = uir_sync[SYNC_STAGES-1];

  // fill marks which synchronizer stages hold a genuine post-reset sample, so a
  // level that was already high across reset is never mistaken for a new edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync  <= '0;
      uir_sync  <= '0;
      fill      <= '0;
      udr_q     <= 1'b0;
      uir_q     <= 1'b0;
      udr_armed <= 1'b0;
      uir_armed <= 1'b0;
    end else begin
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      udr_q     <= udr_out;
      uir_q     <= uir_out;
      udr_armed <= udr_armed | (fill[SYNC_STAGES-1] & ~udr_out);
      uir_armed <= uir_armed | (fill[SYNC_STAGES-1] & ~uir_out);
    end
  end

  assign udr_rise = udr_out & ~udr_q & udr_armed;
  assign uir_rise = uir_out & ~uir_q & uir_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_update <= 1'b0;
    end else begin
      ir_update <= uir_rise;
    end
  end

  // Command FIFO (first-word-fall-through)
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] head;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             drop;

  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign cmd_valid = (level != '0);
  assign push      = udr_rise;
  assign pop       = cmd_valid & cmd_ready;
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {ir_in, sr};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // A fresh drop outranks a coincident clear
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Head is gated so outputs read zero whenever nothing is buffered
  assign head        = mem[rd_ptr];
  assign cmd_ir      = cmd_valid ? head[ENT_W-1:DATA_W] : '0;
  assign jdo         = cmd_valid ? head[DATA_W-1:0] : '0;
  assign take_action = pop ? (ACT_W'(1) << cmd_ir) : '0;

endmodule
